// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO drain-side stream reader.
package fifo_stream_reader_pkg;

  // Default word width; must agree with the FIFO this reader drains.
  localparam int unsigned Width_data_default = 8;

endpackage

// File: rtl/fifo_stream_reader_skid2.sv
// Two-entry order-preserving buffer: head drives the stream, skid holds the
// next word. Occupancy and the valid flag are registered together.
module stream_skid2
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned Width_data = Width_data_default
) (
  input  logic                  sys_clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [Width_data-1:0] push_data,
  input  logic                  pop,
  output logic [Width_data-1:0] head,
  output logic [1:0]            occ,
  output logic                  valid
);

  logic [Width_data-1:0] skid;
  logic [1:0]            occ_next;

  // Occupancy moves by one on push-only or pop-only; simultaneous push/pop holds it.
  always_comb begin
    occ_next = occ;
    if (push && !pop) begin
      occ_next = occ + 2'd1;
    end else if (pop && !push) begin
      occ_next = occ - 2'd1;
    end
  end

  // Shift entries toward head so words leave in arrival order.
  always_ff @(posedge sys_clk) begin
    if (srst) begin
      head  <= '0;
      skid  <= '0;
      occ   <= 2'd0;
      valid <= 1'b0;
    end else begin
      occ   <= occ_next;
      valid <= (occ_next != 2'd0);
      case ({push, pop})
        2'b01: begin
          if (occ == 2'd2) head <= skid;
        end
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             skid <= push_data;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head <= skid;
            skid <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream.
// Pops are issued only when the buffer is guaranteed room for the returning
// word, so the 2-entry buffer never overflows and the FIFO is never over-read.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned Width_data = Width_data_default
) (
  input  logic                  sys_clk,
  input  logic                  srst,
  input  logic                  fifo_empty,
  input  logic [Width_data-1:0] fifo_rd_data,
  input  logic                  fifo_rd_err,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [Width_data-1:0] m_data,
  input  logic                  m_ready,
  output logic                  rd_err_sticky
);

  logic       inflight;
  logic       pop;
  logic [1:0] occ;
  logic [1:0] level;

  assign pop = m_valid & m_ready;

  // Words held plus the word in flight, less the one leaving; never exceeds 2.
  assign level = occ + {1'b0, inflight} - {1'b0, pop};

  assign fifo_rd_en = !srst & !fifo_empty & (level < 2'd2);

  // A pop issued this cycle returns data next cycle; a reset drops it.
  always_ff @(posedge sys_clk) begin
    if (srst) inflight <= 1'b0;
    else      inflight <= fifo_rd_en;
  end

  // Any FIFO read error is remembered until reset.
  always_ff @(posedge sys_clk) begin
    if (srst)             rd_err_sticky <= 1'b0;
    else if (fifo_rd_err) rd_err_sticky <= 1'b1;
  end

  stream_skid2 #(
    .Width_data (Width_data)
  ) u_buf (
    .sys_clk   (sys_clk),
    .srst      (srst),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ),
    .valid     (m_valid)
  );

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain side for the team's synchronous FIFO (sys_clk domain): pops words through the FIFO read port (`fifo_rd_en`, registered `fifo_rd_data` one cycle later, `fifo_empty`) and presents them as a valid/ready master stream. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, giving 1 word/cycle sustained throughput with no bubbles and no over-read. It also latches the FIFO's read-error pulse as a sticky flag.

## Interface
Parameters:
- `Width_data`, 8, word width; must match the FIFO's `Width_data`.

Ports:
- `sys_clk`  in  1  clock. Reset is `srst`, synchronous, active-high; clock is `sys_clk`.
- `srst`  in  1  synchronous active-high reset; shared with the FIFO.
- `fifo_empty`  in  1  FIFO empty flag. Valid every cycle, reflecting the state after the last edge.
- `fifo_rd_data`  in  `Width_data`  FIFO read data. Valid in the cycle after a cycle with `fifo_rd_en`=1 and `fifo_empty`=0.
- `fifo_rd_err`  in  1  FIFO read-error pulse.
- `fifo_rd_en`  out  1  pop request; combinational.
- `m_valid`  out  1  stream data valid; registered.
- `m_data`  out  `Width_data`  stream data; registered.
- `m_ready`  in  1  stream sink ready.
- `rd_err_sticky`  out  1  set by any `fifo_rd_err`=1; cleared only by `srst`.

## Operation
- State:
  - `occ` (0..2): words held in buffer.
  - `inflight` (1 bit): a pop was issued last cycle, so data arrives this cycle.
  - `head`: drives `m_data`.
  - `skid`: second entry.
- `pop` = `m_valid & m_ready`.
- `arrive` = `inflight`. Capture `fifo_rd_data` in this cycle.
- `fifo_rd_en` = `!srst & !fifo_empty & (occ + inflight - pop) < 2`. Never asserted while `fifo_empty`=1, so `fifo_rd_err` is never caused by this block.
- `inflight` next = `fifo_rd_en`.
- Buffer update (order preserved, FIFO order out):
  - pop only: `head` <= `skid` if `occ`=2; `occ`-1.
  - arrive only: write into `head` if `occ`=0, else into `skid`; `occ`+1.
  - pop and arrive, `occ`=1: `head` <= arriving word; `occ` unchanged.
  - pop and arrive, `occ`=2: `head` <= `skid`, `skid` <= arriving word; `occ` unchanged.
  - arrive with `occ`=2 and no pop: unreachable by the credit rule. The bench asserts it never occurs.
- `m_valid` = (`occ` != 0), held registered. `m_data` is stable while `m_valid & !m_ready` (AXI-style hold).
- Width rule: `occ + inflight` is evaluated in 2 bits; no wrap is possible.
- `srst`:
  - `occ`=0, `inflight`=0, `m_valid`=0, `m_data`=0, `skid`=0, `rd_err_sticky`=0, `fifo_rd_en`=0 during reset.
  - A word in flight at reset is discarded. The FIFO is reset by the same `srst`.

## Timing
- Reset values: all registered outputs 0; `fifo_rd_en` 0 while `srst`=1.
- Latency:
  - `fifo_empty` falls before edge E.
  - `fifo_rd_en`=1 in cycle E.
  - Data is valid on `fifo_rd_data` in E+1 and captured at the end of E+1.
  - `m_valid`=1 in cycle E+2. Fixed 2-cycle latency.
- Throughput: with `m_ready` held 1 and the FIFO non-empty, one word per cycle continuously. `fifo_rd_en` stays high.
- Backpressure:
  - `m_ready`=0 stops new pops once `occ + inflight` reaches 2.
  - Exactly one word may land in `skid` after `m_ready` falls.
- Resume: the first cycle with `m_ready`=1 pops `head`. The pop credit is reused the same cycle (`fifo_rd_en` may assert).
- Empty mid-burst: `fifo_empty`=1 gates `fifo_rd_en` the same cycle. The already-inflight word still arrives.
- `rd_err_sticky` rises the cycle after `fifo_rd_err`=1.

## Structure
- No shared-package content beyond `Width_data`. No typedefs needed.
- One natural sub-module: `stream_skid2`, a 2-entry order-preserving buffer with inputs `push`/`push_data`/`pop` and outputs `head`/`occ`.
- The top level holds the credit logic, `inflight`, and the sticky error.

## Test plan
- Reset:
  - Assert `srst` 3 cycles with `fifo_empty`=0 → `fifo_rd_en`=0, `m_valid`=0, `m_data`=0 throughout.
  - Release → `fifo_rd_en`=1 in the next cycle.
- Latency and streaming:
  - Preload the FIFO with 0x11..0x18 and hold `m_ready`=1.
  - Required: `m_valid` rises 2 cycles after the first `fifo_rd_en`.
  - Required: 0x11..0x18 appear on 8 consecutive cycles.
  - Required: `fifo_rd_en` is never high while `fifo_empty`=1.
- Backpressure:
  - Stream 0xA0..0xA7 and drop `m_ready` for 5 cycles mid-burst.
  - Required: at most 2 words buffered and `fifo_rd_en` is held low.
  - Required: `m_data` is stable while stalled.
  - Required: on resume, the output order is intact with no loss or duplication.
- Random:
  - Random `m_ready` (50%) and random FIFO writes for 2000 cycles.
  - Required: the scoreboard shows output equal to the write order.
  - Required: `occ` never exceeds 2 and arrive-at-`occ`=2 never occurs.
- Empty edge:
  - Single write of 0x5A into an empty FIFO.
  - Required: exactly one `fifo_rd_en` pulse, then one `m_valid` beat with 0x5A.
  - Required: `fifo_rd_err` stays 0.
- Reset mid-operation:
  - Assert `srst` with `occ`=2 and `inflight`=1.
  - Required: the next cycle shows `m_valid`=0 and `rd_err_sticky`=0.
  - Required: the discarded words never appear after release.
  - Separately, force one `fifo_rd_err` pulse → `rd_err_sticky`=1 until `srst`.
